addsub_rr_arbiter: RTL and testbench

- Shares one signed add/sub datapath (the team's parameterised AddSub unit, cin tied 0) between NREQ requesters.
- Round-robin grant, operand capture, registered result, and a valid/ready response channel tagged with the requester id.
- Sits between client blocks (ALU front-ends, address generators) and the single adder instance, so only one adder is built.

---
 rtl/addsub_rr_arbiter_pkg.sv | 16 +
 rtl/addsub_rr_arbiter_if.sv | 35 +++
 rtl/addsub.sv | 26 ++
 rtl/addsub_rr_arbiter_rr_grant.sv | 40 ++++
 rtl/addsub_rr_arbiter.sv | 114 +++++++++++
 tb/tb_addsub_rr_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/addsub_rr_arbiter_pkg.sv
// addsub_rr_arbiter_pkg
//   Shared types and constants for the add/sub round-robin arbiter slice.
//   state_t : arbiter FSM states (IDLE=0, EXEC=1, RESP=2, 2-bit)
//   OP_ADD / OP_SUB : encoding of the per-requester req_op bit
package addsub_rr_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/addsub_rr_arbiter_if.sv
// addsub_rr_arbiter_if
//   Request/response bundle between NREQ clients and the shared add/sub arbiter.
//   req_valid/req_ready : per-requester handshake (ready is one-hot or zero)
//   req_a/req_b         : packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_op              : per-requester op, 0 = a+b, 1 = a-b
//   resp_*              : registered result channel tagged with requester id
//   master : client side    slave : arbiter side
interface addsub_rr_arbiter_if #(
   parameter int WIDTH = 4,
   parameter int NREQ  = 4,
   parameter int IDW   = $clog2(NREQ)
);

   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*WIDTH-1:0] req_a;
   logic [NREQ*WIDTH-1:0] req_b;
   logic [NREQ-1:0]       req_op;
   logic                  resp_valid;
   logic                  resp_ready;
   logic [WIDTH-1:0]      resp_result;
   logic                  resp_overflow;
   logic [IDW-1:0]        resp_id;

   modport master (
      output req_valid, req_a, req_b, req_op, resp_ready,
      input  req_ready, resp_valid, resp_result, resp_overflow, resp_id
   );

   modport slave (
      input  req_valid, req_a, req_b, req_op, resp_ready,
      output req_ready, resp_valid, resp_result, resp_overflow, resp_id
   );

endinterface

// File: rtl/addsub.sv
// addsub
//   Parameterised signed add/sub datapath, purely combinational.
//   a, b : WIDTH-bit two's-complement operands
//   cin  : carry in
//   sub  : 0 = a+b+cin, 1 = a+(-b)+cin
//   sum  : result modulo 2^WIDTH
//   ovf  : sign(a)==sign(b') && sign(sum)!=sign(a), b' being the operand
//          actually added; negating MIN yields MIN, so 0-MIN reports no overflow
module addsub #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic [WIDTH-1:0] sum,
   output logic             ovf
);

   logic [WIDTH-1:0] b_eff;

   assign b_eff = sub ? (~b + WIDTH'(1)) : b;
   assign sum   = a + b_eff + WIDTH'(cin);
   assign ovf   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/addsub_rr_arbiter_rr_grant.sv
// rr_grant
//   Combinational round-robin picker.
//   req   : request vector
//   ptr   : highest-priority index (must be < NREQ)
//   grant : one-hot grant of first set req at ptr, ptr+1, ... mod NREQ
//   idx   : binary index of the granted request
//   any   : some request is set
module rr_grant #(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  idx,
   output logic            any
);

   logic [IDW:0] cand;

   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      cand  = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         // one extra bit so ptr+k can be wrapped for non-power-of-two NREQ
         cand = {1'b0, ptr} + (IDW+1)'(k);
         if (cand >= (IDW+1)'(NREQ)) begin
            cand = cand - (IDW+1)'(NREQ);
         end
         if (!any && req[cand[IDW-1:0]]) begin
            any                  = 1'b1;
            idx                  = cand[IDW-1:0];
            grant[cand[IDW-1:0]] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/addsub_rr_arbiter.sv
// addsub_rr_arbiter
//   Shares one add/sub datapath between NREQ requesters.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : request/response bundle (slave side)
//   busy : high while an operation is executing or its response is pending
//   Flow: IDLE grants round-robin and captures operands, EXEC registers the
//   datapath result, RESP holds it until resp_ready. One op per 3 cycles max.
module addsub_rr_arbiter
   import addsub_rr_arbiter_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int NREQ  = 4,
   parameter int IDW   = $clog2(NREQ)
) (
   input  logic              clk,
   input  logic              rst,
   addsub_rr_arbiter_if.slave bus,
   output logic              busy
);

   state_t           state;
   logic [IDW-1:0]   rr_ptr;

   logic [NREQ-1:0]  g_onehot;
   logic [IDW-1:0]   g_idx;
   logic             g_any;

   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             op_sub;
   logic [IDW-1:0]   op_id;

   logic [WIDTH-1:0] dp_sum;
   logic             dp_ovf;

   logic             resp_valid_q;
   logic [WIDTH-1:0] resp_result_q;
   logic             resp_overflow_q;
   logic [IDW-1:0]   resp_id_q;

   rr_grant #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_grant (
      .req   (bus.req_valid),
      .ptr   (rr_ptr),
      .grant (g_onehot),
      .idx   (g_idx),
      .any   (g_any)
   );

   addsub #(
      .WIDTH (WIDTH)
   ) u_addsub (
      .a   (op_a),
      .b   (op_b),
      .cin (1'b0),
      .sub (op_sub),
      .sum (dp_sum),
      .ovf (dp_ovf)
   );

   // grant vector is already zero when nothing is requesting
   assign bus.req_ready     = (state == IDLE) ? g_onehot : '0;
   assign bus.resp_valid    = resp_valid_q;
   assign bus.resp_result   = resp_result_q;
   assign bus.resp_overflow = resp_overflow_q;
   assign bus.resp_id       = resp_id_q;
   assign busy              = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         rr_ptr          <= '0;
         op_a            <= '0;
         op_b            <= '0;
         op_sub          <= OP_ADD;
         op_id           <= '0;
         resp_valid_q    <= 1'b0;
         resp_result_q   <= '0;
         resp_overflow_q <= 1'b0;
         resp_id_q       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (g_any) begin
                  op_a   <= bus.req_a[g_idx*WIDTH +: WIDTH];
                  op_b   <= bus.req_b[g_idx*WIDTH +: WIDTH];
                  op_sub <= (bus.req_op[g_idx] == OP_SUB);
                  op_id  <= g_idx;
                  rr_ptr <= (g_idx == IDW'(NREQ-1)) ? '0 : g_idx + 1'b1;
                  state  <= EXEC;
               end
            end
            EXEC: begin
               resp_result_q   <= dp_sum;
               resp_overflow_q <= dp_ovf;
               resp_id_q       <= op_id;
               resp_valid_q    <= 1'b1;
               state           <= RESP;
            end
            RESP: begin
               if (bus.resp_ready) begin
                  resp_valid_q <= 1'b0;
                  state        <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_addsub_rr_arbiter.sv
// tb_addsub_rr_arbiter
//   Scoreboard bench for addsub_rr_arbiter (WIDTH=4, NREQ=4).
//   Requesters are driven from bench arrays; a negedge monitor predicts each
//   grant from the arbitration rule, pushes the arithmetic reference result,
//   and pops/compares when the DUT presents a response.
module tb_addsub_rr_arbiter;

   localparam int W   = 4;
   localparam int N   = 4;
   localparam int IDW = 2;

   typedef struct {
      int         id;
      logic [W-1:0] res;
      logic       ovf;
      int         gcyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic busy;

   addsub_rr_arbiter_if #(.WIDTH(W), .NREQ(N), .IDW(IDW)) bus ();

   addsub_rr_arbiter #(.WIDTH(W), .NREQ(N), .IDW(IDW)) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus),
      .busy (busy)
   );

   always #5 clk = ~clk;

   // requester-side stimulus state
   logic [N-1:0] vld  = '0;
   logic [N-1:0] vop  = '0;
   logic [W-1:0] va [N];
   logic [W-1:0] vb [N];
   logic         rdy  = 1'b1;
   logic         keep = 1'b0;
   logic [N-1:0] acc;

   assign bus.req_valid  = vld;
   assign bus.req_op     = vop;
   assign bus.resp_ready = rdy;

   always_comb begin
      bus.req_a = '0;
      bus.req_b = '0;
      for (int i = 0; i < N; i++) begin
         bus.req_a[i*W +: W] = va[i];
         bus.req_b[i*W +: W] = vb[i];
      end
   end

   // model / scoreboard state
   exp_t          expq[$];
   int            gorder[$];
   int            mptr     = 0;
   int            inflight = 0;
   int            cyc      = 0;
   int            nchecks  = 0;
   int            nerrors  = 0;
   logic          p_valid  = 1'b0;
   logic          p_ready  = 1'b0;
   logic [W-1:0]  p_res    = '0;
   logic          p_ovf    = 1'b0;
   logic [IDW-1:0] p_id    = '0;
   logic [W-1:0]  last_res = '0;
   logic          last_ovf = 1'b0;
   int            last_id  = -1;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchecks++;
      if (act !== exp) begin
         nerrors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference arithmetic from true signed math; only 0-MIN style subtraction
   // needs the datapath's own rule because negating MIN gives MIN.
   function automatic exp_t model(input int id, input logic [W-1:0] a,
                                  input logic [W-1:0] b, input logic op, input int gc);
      exp_t e;
      int sa, sb, r, lo, hi;
      sa = int'($signed(a));
      sb = int'($signed(b));
      lo = -(1 << (W-1));
      hi = (1 << (W-1)) - 1;
      r  = op ? sa - sb : sa + sb;
      e.id   = id;
      e.res  = r[W-1:0];
      e.ovf  = (r < lo) || (r > hi);
      if (op && sb == lo) e.ovf = (sa < 0);
      e.gcyc = gc;
      return e;
   endfunction

   // monitor
   always @(negedge clk) begin
      logic [N-1:0] exp_rdy;
      int   pick;
      int   j;
      int   gid;
      exp_t e;
      if (rst) begin
         expq.delete();
         inflight = 0;
         mptr     = 0;
         p_valid  = 1'b0;
         p_ready  = 1'b0;
      end else begin
         pick = -1;
         for (int k = 0; k < N; k++) begin
            j = (mptr + k) % N;
            if (pick < 0 && bus.req_valid[j]) pick = j;
         end
         exp_rdy = '0;
         if (inflight == 0 && pick >= 0) exp_rdy[pick] = 1'b1;
         chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
         chk("busy", 32'(busy), 32'(inflight != 0));

         gid = -1;
         for (int k = 0; k < N; k++) if (gid < 0 && bus.req_ready[k]) gid = k;
         if (gid >= 0) gorder.push_back(gid);

         if (exp_rdy != '0) begin
            expq.push_back(model(pick, va[pick], vb[pick], vop[pick], cyc));
            mptr     = (pick + 1) % N;
            inflight = 1;
         end

         if (p_valid && !p_ready) begin
            chk("hold_valid",  32'(bus.resp_valid),    32'(1));
            chk("hold_result", 32'(bus.resp_result),   32'(p_res));
            chk("hold_ovf",    32'(bus.resp_overflow), 32'(p_ovf));
            chk("hold_id",     32'(bus.resp_id),       32'(p_id));
         end else if (bus.resp_valid) begin
            if (expq.size() == 0) begin
               chk("resp_spurious", 32'(bus.resp_valid), 32'(0));
            end else begin
               e = expq.pop_front();
               chk("resp_result",  32'(bus.resp_result),   32'(e.res));
               chk("resp_ovf",     32'(bus.resp_overflow), 32'(e.ovf));
               chk("resp_id",      32'(bus.resp_id),       32'(e.id));
               chk("resp_latency", 32'(cyc - e.gcyc),      32'(2));
               last_res = bus.resp_result;
               last_ovf = bus.resp_overflow;
               last_id  = int'(bus.resp_id);
            end
         end else if (expq.size() > 0 && (cyc - expq[0].gcyc) >= 2) begin
            chk("resp_missing", 32'(bus.resp_valid), 32'(1));
         end

         if (bus.resp_valid && bus.resp_ready) inflight = 0;
         p_valid = bus.resp_valid;
         p_ready = bus.resp_ready;
         p_res   = bus.resp_result;
         p_ovf   = bus.resp_overflow;
         p_id    = bus.resp_id;
      end
   end

   // requesters drop valid after their ready pulse (unless re-requesting)
   initial begin
      forever begin
         @(negedge clk);
         acc = rst ? '0 : bus.req_ready;
         @(posedge clk);
         #1;
         if (!keep) vld = vld & ~acc;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic issue(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
      va[i]  = a;
      vb[i]  = b;
      vop[i] = op;
      vld[i] = 1'b1;
   endtask

   task automatic wait_idle(input string nm);
      bit done;
      done = 1'b0;
      for (int t = 0; t < 300 && !done; t++) begin
         if (vld == '0 && inflight == 0 && !bus.resp_valid) done = 1'b1;
         else tick(1);
      end
      chk(nm, 32'(done), 32'(1));
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      nerrors++;
      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
      $finish;
   end

   initial begin
      int exp_order[5];
      bit seen;
      for (int i = 0; i < N; i++) begin
         va[i] = '0;
         vb[i] = '0;
      end
      exp_order = '{0, 1, 2, 3, 0};

      // reset state
      rst = 1'b1;
      tick(3);
      rst = 1'b0;
      @(negedge clk);
      #1;
      chk("rst_resp_valid",  32'(bus.resp_valid),    32'(0));
      chk("rst_busy",        32'(busy),              32'(0));
      chk("rst_result",      32'(bus.resp_result),   32'(0));
      chk("rst_ovf",         32'(bus.resp_overflow), 32'(0));
      chk("rst_id",          32'(bus.resp_id),       32'(0));
      chk("rst_req_ready",   32'(bus.req_ready),     32'(0));

      // single request on requester 2
      tick(1);
      gorder.delete();
      issue(2, 4'd3, 4'd4, 1'b0);
      wait_idle("single_idle");
      chk("single_grants", 32'(gorder.size()), 32'(1));
      chk("single_res",    32'(last_res), 32'(7));
      chk("single_ovf",    32'(last_ovf), 32'(0));
      chk("single_id",     32'(last_id),  32'(2));

      // signed overflow corners
      issue(0, 4'd7, 4'd1, 1'b0);
      wait_idle("ovf1_idle");
      chk("ovf1_res", 32'(last_res), 32'h8);
      chk("ovf1_ovf", 32'(last_ovf), 32'(1));
      issue(1, 4'h8, 4'd1, 1'b1);
      wait_idle("ovf2_idle");
      chk("ovf2_res", 32'(last_res), 32'h7);
      chk("ovf2_ovf", 32'(last_ovf), 32'(1));
      issue(3, 4'd5, 4'd3, 1'b1);
      wait_idle("ovf3_idle");
      chk("ovf3_res", 32'(last_res), 32'h2);
      chk("ovf3_ovf", 32'(last_ovf), 32'(0));
      issue(0, 4'd0, 4'h8, 1'b1);
      wait_idle("min_idle");
      chk("min_res", 32'(last_res), 32'h8);
      chk("min_ovf", 32'(last_ovf), 32'(0));

      // all four requesters continuously valid from reset
      reset_dut();
      gorder.delete();
      keep = 1'b1;
      for (int i = 0; i < N; i++) issue(i, W'($urandom), W'($urandom), 1'($urandom));
      for (int t = 0; t < 60 && gorder.size() < 5; t++) tick(1);
      keep = 1'b0;
      vld  = '0;
      chk("order_count", 32'(gorder.size() >= 5), 32'(1));
      for (int k = 0; k < 5; k++) begin
         if (k < gorder.size()) chk("order", 32'(gorder[k]), 32'(exp_order[k]));
      end
      wait_idle("order_idle");

      // back-pressure: result held for 10 cycles, next grant right after consume
      rdy = 1'b0;
      issue(1, 4'd6, 4'd5, 1'b0);
      seen = 1'b0;
      for (int t = 0; t < 20 && !seen; t++) begin
         if (bus.resp_valid) seen = 1'b1;
         else tick(1);
      end
      chk("bp_resp_seen", 32'(seen), 32'(1));
      issue(2, 4'd2, 4'd7, 1'b1);
      tick(10);
      rdy = 1'b1;
      wait_idle("bp_idle");

      // pointer skip: ptr=1 with only requesters 0 and 3 valid
      reset_dut();
      issue(0, 4'd1, 4'd1, 1'b0);
      wait_idle("skip_pre_idle");
      gorder.delete();
      issue(0, 4'd2, 4'd3, 1'b1);
      issue(3, 4'd4, 4'd4, 1'b0);
      wait_idle("skip_idle");
      chk("skip_count", 32'(gorder.size()), 32'(2));
      if (gorder.size() >= 2) begin
         chk("skip_first",  32'(gorder[0]), 32'(3));
         chk("skip_second", 32'(gorder[1]), 32'(0));
      end

      // reset while in EXEC
      issue(2, 4'd1, 4'd1, 1'b0);
      seen = 1'b0;
      for (int t = 0; t < 20 && !seen; t++) begin
         if (busy && !bus.resp_valid) seen = 1'b1;
         else tick(1);
      end
      chk("exec_reached", 32'(seen), 32'(1));
      reset_dut();
      @(negedge clk);
      #1;
      chk("rstexec_valid", 32'(bus.resp_valid), 32'(0));
      chk("rstexec_busy",  32'(busy),           32'(0));
      tick(1);
      gorder.delete();
      issue(1, 4'd3, 4'd2, 1'b0);
      issue(0, 4'd3, 4'd2, 1'b1);
      wait_idle("rstexec_idle");
      chk("rstexec_count", 32'(gorder.size()), 32'(2));
      if (gorder.size() >= 2) begin
         chk("rstexec_first",  32'(gorder[0]), 32'(0));
         chk("rstexec_second", 32'(gorder[1]), 32'(1));
      end

      // randomized traffic with random back-pressure and request withdrawal
      for (int t = 0; t < 1500; t++) begin
         tick(1);
         for (int i = 0; i < N; i++) begin
            if (!vld[i] && ($urandom % 3) == 0)
               issue(i, W'($urandom), W'($urandom), 1'($urandom));
            else if (vld[i] && ($urandom % 40) == 0)
               vld[i] = 1'b0;
         end
         rdy = (($urandom % 4) != 0);
      end
      rdy = 1'b1;
      wait_idle("random_idle");

      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
      $finish;
   end

endmodule
